// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: byte/halfword/word loads and stores against a
// little-endian byte array with fixed multi-cycle latency, stalling the pipeline via BUSYWAIT.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT
);

  localparam logic [3:0] CODE_LB  = 4'b1000;
  localparam logic [3:0] CODE_LH  = 4'b1001;
  localparam logic [3:0] CODE_LW  = 4'b1010;
  localparam logic [3:0] CODE_LBU = 4'b1100;
  localparam logic [3:0] CODE_LHU = 4'b1101;
  localparam logic [3:0] CODE_SB  = 4'b0101;
  localparam logic [3:0] CODE_SH  = 4'b0110;
  localparam logic [3:0] CODE_SW  = 4'b0111;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_load(input logic [3:0] code);
    case (code)
      CODE_LB, CODE_LH, CODE_LW, CODE_LBU, CODE_LHU: is_load = 1'b1;
      default:                                       is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_valid(input logic [3:0] code);
    case (code)
      CODE_SB, CODE_SH, CODE_SW: is_valid = 1'b1;
      default:                   is_valid = is_load(code);
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [3:0] code, input logic [31:0] word,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (code)
      CODE_LB:  extend_load = {{24{b[7]}}, b};
      CODE_LH:  extend_load = {{16{h[15]}}, h};
      CODE_LW:  extend_load = word;
      CODE_LBU: extend_load = {24'd0, b};
      CODE_LHU: extend_load = {16'd0, h};
      default:  extend_load = 32'd0;
    endcase
  endfunction

  state_t                  state_r, state_next_s;
  logic [3:0]              cnt_r, cnt_next_s;
  logic [3:0]              code_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             wdata_r;
  logic                    latch_s;
  logic                    complete_s;
  logic [31:0]             rd_word_s;
  logic [7:0]              mem_r [0:(2**ADDR_WIDTH)-1];
  logic                    unused_addr_s;

  assign unused_addr_s = ^ADDRESS[31:ADDR_WIDTH];

  // Assembles the addressed word from its four bytes, lane 0 in the low byte.
  assign rd_word_s = {mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b11}], mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b10}],
                      mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b01}], mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b00}]};

  // Next-state, counter and stall decode; RESET forces the stall low and blocks completion.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    latch_s      = 1'b0;
    complete_s   = 1'b0;
    BUSYWAIT     = 1'b0;
    case (state_r)
      IDLE: begin
        BUSYWAIT = is_valid(READ_WRITE);
        if (is_valid(READ_WRITE)) begin
          latch_s      = 1'b1;
          cnt_next_s   = CNT_INIT;
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        if (cnt_r == 4'd0) begin
          complete_s   = 1'b1;
          state_next_s = DONE;
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
    if (RESET) begin
      BUSYWAIT   = 1'b0;
      complete_s = 1'b0;
      latch_s    = 1'b0;
    end else begin
      BUSYWAIT   = BUSYWAIT;
    end
  end

  // State, counter and load result registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      READ_DATA <= 32'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (complete_s && is_load(code_r)) begin
        READ_DATA <= extend_load(code_r, rd_word_s, addr_r[1:0]);
      end
    end
  end

  // Operand latch: inputs are captured once in IDLE and ignored while the access runs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      code_r  <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
    end else if (latch_s) begin
      code_r  <= READ_WRITE;
      addr_r  <= ADDRESS[ADDR_WIDTH-1:0];
      wdata_r <= WRITE_DATA;
    end
  end

  // Store commit; memory contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (complete_s) begin
      case (code_r)
        CODE_SB: mem_r[addr_r] <= wdata_r[7:0];
        CODE_SH: begin
          mem_r[{addr_r[ADDR_WIDTH-1:1], 1'b0}] <= wdata_r[7:0];
          mem_r[{addr_r[ADDR_WIDTH-1:1], 1'b1}] <= wdata_r[15:8];
        end
        CODE_SW: begin
          mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b00}] <= wdata_r[7:0];
          mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b01}] <= wdata_r[15:8];
          mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b10}] <= wdata_r[23:16];
          mem_r[{addr_r[ADDR_WIDTH-1:2], 2'b11}] <= wdata_r[31:24];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=4, ADDR_WIDTH=10).
module tb_data_mem_responder;

  logic        CLK;
  logic        RESET;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] NONE = 4'b0000, LB = 4'b1000, LH = 4'b1001, LW = 4'b1010,
                         LBU = 4'b1100, LHU = 4'b1101, SB = 4'b0101, SH = 4'b0110,
                         SW = 4'b0111;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issues one request in IDLE, counts stall cycles, returns READ_DATA from the DONE cycle.
  task automatic access(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wd,
                        output int busy_n, output logic [31:0] rd);
    @(posedge CLK); #1;
    READ_WRITE = code; ADDRESS = addr; WRITE_DATA = wd;
    #1;
    busy_n = 0;
    while (BUSYWAIT === 1'b1 && busy_n < 20) begin
      busy_n++;
      @(posedge CLK); #2;
    end
    rd = READ_DATA;
    READ_WRITE = NONE;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ_WRITE = SW; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
    @(posedge CLK); #2;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSYWAIT); end
    @(posedge CLK); #2;
    total++; if (READ_DATA !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", READ_DATA); end
    RESET = 1'b0; READ_WRITE = NONE; #1;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", BUSYWAIT); end
  endtask

  task automatic test_word();
    int n; logic [31:0] rd;
    access(SW, 32'h10, 32'hDEADBEEF, n, rd);
    total++; if (n !== 5) begin bad++; $display("FAIL sw_busy got=%0d exp=5", n); end
    access(LW, 32'h10, 32'h0, n, rd);
    total++; if (n !== 5) begin bad++; $display("FAIL lw_busy got=%0d exp=5", n); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_loads();
    int n; logic [31:0] rd;
    access(LB, 32'h13, 32'h0, n, rd);
    total++; if (rd !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb13 got=%h exp=ffffffde", rd); end
    access(LBU, 32'h13, 32'h0, n, rd);
    total++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL lbu13 got=%h exp=000000de", rd); end
    access(LB, 32'h10, 32'h0, n, rd);
    total++; if (rd !== 32'hFFFFFFEF) begin bad++; $display("FAIL lb10 got=%h exp=ffffffef", rd); end
    access(LBU, 32'h11, 32'h0, n, rd);
    total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL lbu11 got=%h exp=000000be", rd); end
  endtask

  task automatic test_byte_merge();
    int n; logic [31:0] rd;
    access(SB, 32'h11, 32'h12345655, n, rd);
    total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL sb_hold got=%h exp=000000be", rd); end
    access(LW, 32'h10, 32'h0, n, rd);
    total++; if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge got=%h exp=dead55ef", rd); end
  endtask

  task automatic test_halfword();
    int n; logic [31:0] rd;
    access(SH, 32'h12, 32'hABCD8001, n, rd);
    access(LH, 32'h12, 32'h0, n, rd);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh12 got=%h exp=ffff8001", rd); end
    access(LHU, 32'h13, 32'h0, n, rd);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu13 got=%h exp=00008001", rd); end
    access(LW, 32'h10, 32'h0, n, rd);
    total++; if (rd !== 32'h800155EF) begin bad++; $display("FAIL sh_merge got=%h exp=800155ef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pat;
    @(posedge CLK); #1;
    READ_WRITE = LW; ADDRESS = 32'h10; WRITE_DATA = 32'h0;
    #1; pat[0] = BUSYWAIT;
    for (int i = 1; i < 12; i++) begin
      @(posedge CLK); #2; pat[i] = BUSYWAIT;
    end
    total++; if (pat !== 12'h7DF) begin bad++; $display("FAIL b2b_pattern got=%b exp=011111011111", pat); end
    total++; if (READ_DATA !== 32'h800155EF) begin bad++; $display("FAIL b2b_data got=%h exp=800155ef", READ_DATA); end
    READ_WRITE = NONE;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL none_busy%0d got=%b exp=0", i, BUSYWAIT); end
      total++; if (READ_DATA !== 32'h800155EF) begin bad++; $display("FAIL none_hold%0d got=%h exp=800155ef", i, READ_DATA); end
    end
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] rd;
    access(SW, 32'h20, 32'h0BADF00D, n, rd);
    @(posedge CLK); #1;
    READ_WRITE = SW; ADDRESS = 32'h20; WRITE_DATA = 32'hCAFEF00D;
    repeat (4) @(posedge CLK);
    #1; RESET = 1'b1; #1;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", BUSYWAIT); end
    @(posedge CLK); #1;
    RESET = 1'b0; READ_WRITE = NONE; #1;
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", BUSYWAIT); end
    total++; if (READ_DATA !== 32'd0) begin bad++; $display("FAIL post_rst_rdata got=%h exp=00000000", READ_DATA); end
    access(LW, 32'h20, 32'h0, n, rd);
    total++; if (n !== 5) begin bad++; $display("FAIL post_rst_lw_busy got=%0d exp=5", n); end
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL aborted_store got=%h exp=0badf00d", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_loads();
    test_byte_merge();
    test_halfword();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
